// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcode encodings, instruction field
// positions, the NOP encoding and the immediate extender.
package decode_pkg;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    localparam int OP_HI    = 21;
    localparam int OP_LO    = 20;
    localparam int FUNCT_HI = 19;
    localparam int FUNCT_LO = 16;
    localparam int RN_HI    = 15;
    localparam int RN_LO    = 12;
    localparam int RD_HI    = 11;
    localparam int RD_LO    = 8;
    localparam int SRC2_HI  = 7;
    localparam int SRC2_LO  = 0;
    localparam int RM_HI    = 3;
    localparam int RM_LO    = 0;
    localparam int L_BIT    = 16;
    localparam int BR_HI    = 19;

    localparam logic [21:0] NOP_INSTR = 22'h0;
    localparam logic [3:0]  PC_REG    = 4'd15;

    // Branch offsets are word offsets, so the shift by two already fills bit 21 with instr[19].
    function automatic logic [21:0] extend_imm(input logic [21:0] instr);
        logic [21:0] imm;
        imm = 22'h0;
        case (op_e'(instr[OP_HI:OP_LO]))
            OP_DP:   imm = {14'h0, instr[SRC2_HI:SRC2_LO]};
            OP_MEM:  imm = {14'h0, instr[SRC2_HI:SRC2_LO]};
            OP_BR:   imm = {instr[BR_HI:0], 2'b00};
            OP_RSV:  imm = 22'h0;
            default: imm = 22'h0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file: R0-R14 stored, R15 reads return the fetch PC,
// and a same-cycle writeback is bypassed to both read ports.
module register_file
    import decode_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int WIDTH = 22,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [WIDTH-1:0] pc_val,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    logic [WIDTH-1:0] r_mem [0:NREGS-2];

    function automatic logic [WIDTH-1:0] read_port(
        input logic [AW-1:0]    addr,
        input logic             wr_en,
        input logic [AW-1:0]    wr_addr,
        input logic [WIDTH-1:0] wr_data,
        input logic [WIDTH-1:0] pc,
        input logic [WIDTH-1:0] stored
    );
        logic [WIDTH-1:0] val;
        if (addr == PC_REG) begin
            val = pc;
        end else if (wr_en && (wr_addr == addr)) begin
            val = wr_data;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Storage for R0-R14; writes aimed at the PC slot are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS - 1; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (we && (wa != PC_REG)) begin
            r_mem[wa] <= wd;
        end else begin
            r_mem <= r_mem;
        end
    end

    // Combinational read ports with PC substitution and write-through bypass.
    always_comb begin
        rd1 = {WIDTH{1'b0}};
        rd2 = {WIDTH{1'b0}};
        if (ra1 == PC_REG) begin
            rd1 = read_port(ra1, we, wa, wd, pc_val, {WIDTH{1'b0}});
        end else begin
            rd1 = read_port(ra1, we, wa, wd, pc_val, r_mem[ra1]);
        end
        if (ra2 == PC_REG) begin
            rd2 = read_port(ra2, we, wa, wd, pc_val, {WIDTH{1'b0}});
        end else begin
            rd2 = read_port(ra2, we, wa, wd, pc_val, r_mem[ra2]);
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID pipeline register with flush/stall, field decode,
// source-register selection, immediate extension and register-file reads.
module decode_stage
    import decode_pkg::*;
#(
    parameter int WIDTH = 22,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallD,
    input  logic             flushD,
    input  logic [WIDTH-1:0] instruction_fetch_in,
    input  logic [WIDTH-1:0] pc_plus_8_in,
    input  logic             reg_write_w,
    input  logic [3:0]       wa3_w,
    input  logic [WIDTH-1:0] result_w,
    output logic [WIDTH-1:0] instruction_decode_out,
    output logic             valid_d,
    output logic [1:0]       op_d,
    output logic [3:0]       funct_d,
    output logic [3:0]       ra1_d,
    output logic [3:0]       ra2_d,
    output logic [3:0]       wa3_d,
    output logic [WIDTH-1:0] rd1_d,
    output logic [WIDTH-1:0] rd2_d,
    output logic [WIDTH-1:0] ext_imm_d
);

    logic [WIDTH-1:0] r_instr;
    logic             r_valid;
    op_e              w_op;
    logic [3:0]       w_ra1;
    logic [3:0]       w_ra2;

    // IF/ID register: flush beats stall, stall holds, otherwise capture fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (flushD) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (stallD) begin
            r_instr <= r_instr;
            r_valid <= r_valid;
        end else begin
            r_instr <= instruction_fetch_in;
            r_valid <= 1'b1;
        end
    end

    // Source selection: branches read the PC, stores read rd as their data operand.
    always_comb begin
        w_op  = op_e'(r_instr[OP_HI:OP_LO]);
        w_ra1 = r_instr[RN_HI:RN_LO];
        w_ra2 = r_instr[RM_HI:RM_LO];
        if (w_op == OP_BR) begin
            w_ra1 = PC_REG;
        end else begin
            w_ra1 = r_instr[RN_HI:RN_LO];
        end
        if ((w_op == OP_MEM) && !r_instr[L_BIT]) begin
            w_ra2 = r_instr[RD_HI:RD_LO];
        end else begin
            w_ra2 = r_instr[RM_HI:RM_LO];
        end
    end

    register_file #(
        .NREGS (NREGS),
        .WIDTH (WIDTH)
    ) u_register_file (
        .clk    (clk),
        .rst    (rst),
        .ra1    (w_ra1),
        .ra2    (w_ra2),
        .we     (reg_write_w),
        .wa     (wa3_w),
        .wd     (result_w),
        .pc_val (pc_plus_8_in),
        .rd1    (rd1_d),
        .rd2    (rd2_d)
    );

    assign instruction_decode_out = r_instr;
    assign valid_d                = r_valid;
    assign op_d                   = r_instr[OP_HI:OP_LO];
    assign funct_d                = r_instr[FUNCT_HI:FUNCT_LO];
    assign ra1_d                  = w_ra1;
    assign ra2_d                  = w_ra2;
    assign wa3_d                  = r_instr[RD_HI:RD_LO];
    assign ext_imm_d              = extend_imm(r_instr);

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: a behavioural model of the pipeline
// register and register file, checked every cycle, plus directed literal checks.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        stallD;
    logic        flushD;
    logic [21:0] instruction_fetch_in;
    logic [21:0] pc_plus_8_in;
    logic        reg_write_w;
    logic [3:0]  wa3_w;
    logic [21:0] result_w;
    logic [21:0] instruction_decode_out;
    logic        valid_d;
    logic [1:0]  op_d;
    logic [3:0]  funct_d;
    logic [3:0]  ra1_d;
    logic [3:0]  ra2_d;
    logic [3:0]  wa3_d;
    logic [21:0] rd1_d;
    logic [21:0] rd2_d;
    logic [21:0] ext_imm_d;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    decode_stage #(.WIDTH(22), .NREGS(16)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .stallD                 (stallD),
        .flushD                 (flushD),
        .instruction_fetch_in   (instruction_fetch_in),
        .pc_plus_8_in           (pc_plus_8_in),
        .reg_write_w            (reg_write_w),
        .wa3_w                  (wa3_w),
        .result_w               (result_w),
        .instruction_decode_out (instruction_decode_out),
        .valid_d                (valid_d),
        .op_d                   (op_d),
        .funct_d                (funct_d),
        .ra1_d                  (ra1_d),
        .ra2_d                  (ra2_d),
        .wa3_d                  (wa3_d),
        .rd1_d                  (rd1_d),
        .rd2_d                  (rd2_d),
        .ext_imm_d              (ext_imm_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [21:0] act, input logic [21:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [21:0] m_instr;
    logic        m_valid;
    logic [21:0] m_rf [0:14];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_instr <= 22'h0;
            m_valid <= 1'b0;
            for (int i = 0; i < 15; i++) m_rf[i] <= 22'h0;
        end else begin
            if (flushD) begin
                m_instr <= 22'h0;
                m_valid <= 1'b0;
            end else if (!stallD) begin
                m_instr <= instruction_fetch_in;
                m_valid <= 1'b1;
            end
            if (reg_write_w && wa3_w != 4'd15) m_rf[wa3_w] <= result_w;
        end
    end

    function automatic logic [21:0] model_read(input logic [3:0] a);
        if (a == 4'd15) return pc_plus_8_in;
        if (reg_write_w && wa3_w == a) return result_w;
        return m_rf[a];
    endfunction

    int          e_op;
    logic [3:0]  e_ra1;
    logic [3:0]  e_ra2;
    logic [21:0] e_ext;

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            e_op  = int'(m_instr / 22'h100000);
            e_ra1 = (e_op == 2) ? 4'd15 : 4'((m_instr / 22'h1000) % 22'h10);
            if (e_op == 1 && ((m_instr / 22'h10000) % 22'h2) == 22'h0)
                e_ra2 = 4'((m_instr / 22'h100) % 22'h10);
            else
                e_ra2 = 4'(m_instr % 22'h10);
            if (e_op == 0 || e_op == 1) e_ext = m_instr % 22'h100;
            else if (e_op == 2)         e_ext = (m_instr % 22'h100000) * 22'h4;
            else                        e_ext = 22'h0;
            chk("instr", instruction_decode_out, m_instr);
            chk("valid", {21'h0, valid_d}, {21'h0, m_valid});
            chk("op", {20'h0, op_d}, 22'(e_op));
            chk("funct", {18'h0, funct_d}, (m_instr / 22'h10000) % 22'h10);
            chk("wa3", {18'h0, wa3_d}, (m_instr / 22'h100) % 22'h10);
            chk("ra1", {18'h0, ra1_d}, {18'h0, e_ra1});
            chk("ra2", {18'h0, ra2_d}, {18'h0, e_ra2});
            chk("rd1", rd1_d, model_read(e_ra1));
            chk("rd2", rd2_d, model_read(e_ra2));
            chk("ext_imm", ext_imm_d, e_ext);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stallD = 1'b0; flushD = 1'b0; reg_write_w = 1'b0;
        wa3_w = 4'd0; result_w = 22'h0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        instruction_fetch_in = 22'h0;
        pc_plus_8_in = 22'h0;
        step();
        cmp_en = 1'b1;
        step();
        rst = 1'b1;

        // Write R3 while fetching op00 rn=3 rd=0 rm=3
        reg_write_w = 1'b1; wa3_w = 4'd3; result_w = 22'h12345;
        instruction_fetch_in = 22'h003003;
        step();
        reg_write_w = 1'b0;
        @(negedge clk); #1;
        chk("lit_rd1_r3", rd1_d, 22'h12345);
        chk("lit_rd2_r3", rd2_d, 22'h12345);
        chk("lit_valid", {21'h0, valid_d}, 22'h1);

        // Same-cycle bypass while holding the instruction
        stallD = 1'b1; reg_write_w = 1'b1; wa3_w = 4'd3; result_w = 22'h0ABCD;
        @(negedge clk); #1;
        chk("lit_bypass", rd1_d, 22'h0ABCD);
        step();
        idle_inputs();

        // Branch reads PC through R15
        instruction_fetch_in = 22'h2FFFFF; pc_plus_8_in = 22'h000100;
        step();
        @(negedge clk); #1;
        chk("lit_br_ra1", {18'h0, ra1_d}, 22'd15);
        chk("lit_br_rd1", rd1_d, 22'h000100);
        chk("lit_br_imm", ext_imm_d, 22'h3FFFFC);

        // Store vs load operand selection
        instruction_fetch_in = 22'h1015F2;
        step();
        @(negedge clk); #1;
        chk("lit_st_ra2", {18'h0, ra2_d}, 22'd5);
        chk("lit_st_imm", ext_imm_d, 22'h0000F2);
        instruction_fetch_in = 22'h1115F2;
        step();
        @(negedge clk); #1;
        chk("lit_ld_ra2", {18'h0, ra2_d}, 22'd2);

        // Stall with a changing fetch input
        stallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instruction_fetch_in = 22'($urandom);
            step();
            chk("lit_stall", instruction_decode_out, 22'h1115F2);
        end
        flushD = 1'b1;
        step();
        chk("lit_flush_instr", instruction_decode_out, 22'h0);
        chk("lit_flush_valid", {21'h0, valid_d}, 22'h0);
        idle_inputs();

        // Write to R15 is ignored; R15 reads keep returning the PC
        reg_write_w = 1'b1; wa3_w = 4'd15; result_w = 22'h3FFFFF;
        instruction_fetch_in = 22'h00F004; pc_plus_8_in = 22'h0ABC00;
        step();
        reg_write_w = 1'b0;
        @(negedge clk); #1;
        chk("lit_r15_rd1", rd1_d, 22'h0ABC00);
        chk("lit_r4_rd2", rd2_d, 22'h0);

        // Asynchronous reset mid-cycle
        instruction_fetch_in = 22'h003003;
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("lit_rst_valid", {21'h0, valid_d}, 22'h0);
        chk("lit_rst_instr", instruction_decode_out, 22'h0);
        chk("lit_rst_rd1", rd1_d, 22'h0);
        chk("lit_rst_rd2", rd2_d, 22'h0);
        chk("lit_rst_imm", ext_imm_d, 22'h0);
        step();
        rst = 1'b1;

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            stallD               = ($urandom_range(0, 3) == 0);
            flushD               = ($urandom_range(0, 7) == 0);
            instruction_fetch_in = 22'($urandom);
            pc_plus_8_in         = 22'($urandom);
            reg_write_w          = ($urandom_range(0, 1) == 1);
            wa3_w                = 4'($urandom);
            result_w             = 22'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst = 1'b0;
                step();
                rst = 1'b1;
            end else begin
                step();
            end
        end

        idle_inputs();
        step();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
